// File: rtl/turn_sequencer.sv
// turn_sequencer: enforces leader/follower card entry for the black-and-white
// card game. Button presses are edge detected, each confirm is checked against
// the active player's remaining cards, and valid confirms become one-cycle
// commit pulses. The winner of a match leads the next round.
// Optional feature macro: TURN_TIMEOUT_EN adds a per-turn idle watchdog that
// auto-plays the lowest-index remaining card after TIMEOUT_CYCLES cycles.
module turn_sequencer #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_center,
  input  logic       btn_top,
  input  logic       btn_bottom,
  input  logic [8:0] sw_card,
  input  logic [8:0] p1_avail,
  input  logic [8:0] p2_avail,
  input  logic       result_valid,
  input  logic [1:0] match_result,
  input  logic       game_over,
  output logic       p1_commit,
  output logic       p2_commit,
  output logic [3:0] commit_idx,
  output logic [8:0] commit_onehot,
  output logic [1:0] turn,
  output logic       leader,
  output logic       reveal_ready,
  output logic       sel_err,
  output logic       timeout,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEAD   = 2'b01,
    FOLLOW = 2'b10,
    REVEAL = 2'b11
  } state_t;

  state_t     state_reg;
  logic       leader_reg;
  logic       p1_commit_reg;
  logic       p2_commit_reg;
  logic       sel_err_reg;
  logic       timeout_reg;
  logic [3:0] commit_idx_reg;
  logic [8:0] commit_onehot_reg;
  logic       btn_center_q;
  logic       btn_top_q;
  logic       btn_bottom_q;

  // Rising-edge press events: a held button yields a single event.
  logic center_press;
  logic top_press;
  logic bottom_press;
  assign center_press = btn_center & ~btn_center_q;
  assign top_press    = btn_top    & ~btn_top_q;
  assign bottom_press = btn_bottom & ~btn_bottom_q;

  // The leader plays in LEAD, the other player in FOLLOW.
  logic       in_turn;
  logic       active_p2;
  logic [8:0] active_avail;
  assign in_turn      = (state_reg == LEAD) || (state_reg == FOLLOW);
  assign active_p2    = (state_reg == FOLLOW) ^ leader_reg;
  assign active_avail = active_p2 ? p2_avail : p1_avail;

  // A confirm is legal only for exactly one card the player still holds.
  logic sw_onehot;
  logic sel_valid;
  assign sw_onehot = (sw_card != 9'd0) && ((sw_card & (sw_card - 9'd1)) == 9'd0);
  assign sel_valid = sw_onehot && ((sw_card & active_avail) == sw_card);

  logic       auto_fire;
  logic       do_commit;
  logic [8:0] commit_sel;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] turn_cnt_reg;
  logic [8:0]  auto_onehot;
  // Lowest-index set bit of the active player's hand.
  assign auto_onehot = active_avail & (~active_avail + 9'd1);
  assign auto_fire   = in_turn && !top_press && (turn_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign commit_sel  = top_press ? sw_card : auto_onehot;
  assign do_commit   = (top_press && sel_valid) || (auto_fire && (auto_onehot != 9'd0));

  // Idle counter: restarts on turn entry, on any confirm and after each auto-play.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      turn_cnt_reg <= 32'd0;
    end else if (bottom_press || !in_turn || top_press || auto_fire) begin
      turn_cnt_reg <= 32'd0;
    end else begin
      turn_cnt_reg <= turn_cnt_reg + 32'd1;
    end
  end
`else
  // Watchdog compiled out; the parameter has no effect in this build.
  assign auto_fire  = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign commit_sel = sw_card;
  assign do_commit  = top_press && sel_valid;
`endif

  function automatic logic [3:0] onehot_to_idx(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Turn FSM with registered pulse and commit outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      leader_reg        <= 1'b0;
      p1_commit_reg     <= 1'b0;
      p2_commit_reg     <= 1'b0;
      sel_err_reg       <= 1'b0;
      timeout_reg       <= 1'b0;
      commit_idx_reg    <= 4'd0;
      commit_onehot_reg <= 9'd0;
      btn_center_q      <= 1'b0;
      btn_top_q         <= 1'b0;
      btn_bottom_q      <= 1'b0;
    end else begin
      btn_center_q  <= btn_center;
      btn_top_q     <= btn_top;
      btn_bottom_q  <= btn_bottom;
      p1_commit_reg <= 1'b0;
      p2_commit_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      if (bottom_press) begin
        state_reg  <= IDLE;
        leader_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (center_press) begin
              state_reg  <= LEAD;
              leader_reg <= 1'b0;
            end
          end
          LEAD, FOLLOW: begin
            if (do_commit) begin
              p1_commit_reg     <= ~active_p2;
              p2_commit_reg     <= active_p2;
              commit_idx_reg    <= onehot_to_idx(commit_sel);
              commit_onehot_reg <= commit_sel;
              state_reg         <= (state_reg == LEAD) ? FOLLOW : REVEAL;
            end else if (top_press) begin
              sel_err_reg <= 1'b1;
            end
            timeout_reg <= auto_fire;
          end
          REVEAL: begin
            if (result_valid) begin
              if (match_result == 2'b01) leader_reg <= 1'b0;
              else if (match_result == 2'b10) leader_reg <= 1'b1;
              state_reg <= game_over ? IDLE : LEAD;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    turn = 2'b00;
    if (in_turn) turn = active_p2 ? 2'b10 : 2'b01;
  end

  assign p1_commit     = p1_commit_reg;
  assign p2_commit     = p2_commit_reg;
  assign commit_idx    = commit_idx_reg;
  assign commit_onehot = commit_onehot_reg;
  assign leader        = leader_reg;
  assign reveal_ready  = (state_reg == REVEAL);
  assign sel_err       = sel_err_reg;
  assign timeout       = timeout_reg;
  assign state_o       = state_reg;

endmodule
